// File: rtl/trig_scheduler_if.sv
// Request/response bundle for the shared sin/cos scheduler.
// master = requesters + result consumer, slave = scheduler.
interface trig_scheduler_if #(
  parameter int N_REQ      = 4,
  parameter int FLOAT_BITS = 32,
  parameter int ID_BITS    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*FLOAT_BITS-1:0] req_angle;
  logic [N_REQ-1:0]            req_ready;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [ID_BITS-1:0]          resp_id;
  logic [FLOAT_BITS-1:0]       resp_sin;
  logic [FLOAT_BITS-1:0]       resp_cos;

  modport master (
    output req_valid, req_angle, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sin, resp_cos
  );

  modport slave (
    input  req_valid, req_angle, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sin, resp_cos
  );
endinterface

// File: rtl/trig_scheduler.sv
// Shared sin/cos scheduler: round-robin arbitration over N_REQ clients,
// iterative range reduction to [-pi, pi), then one combinational sin
// polynomial used twice (sin(x), then sin(pi/2 - x) for cos).
module trig_scheduler #(
  parameter int N_REQ          = 4,
  parameter int ID_BITS        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int FLOAT_BITS     = 32,
  parameter int FLOAT_DCM_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  trig_scheduler_if.slave  bus,
  output logic             busy
);

  // Two guard bits so angle +/- 2pi never overflows during reduction.
  localparam int XW = FLOAT_BITS + 2;
  localparam int F  = FLOAT_DCM_BITS;

  localparam int PI_I      = $rtoi(3.141592653589793 * (2.0 ** F) + 0.5);
  localparam int HALF_PI_I = $rtoi(1.5707963267948966 * (2.0 ** F) + 0.5);
  localparam int TWO_PI_I  = $rtoi(6.283185307179586 * (2.0 ** F) + 0.5);

  localparam logic signed [XW-1:0] PI      = XW'(PI_I);
  localparam logic signed [XW-1:0] NEG_PI  = -PI;
  localparam logic signed [XW-1:0] HALF_PI = XW'(HALF_PI_I);
  localparam logic signed [XW-1:0] NEG_HPI = -HALF_PI;
  localparam logic signed [XW-1:0] TWO_PI  = XW'(TWO_PI_I);

  // Taylor coefficients 1/6 and 1/120 in the same fraction format.
  localparam logic signed [63:0] C6   = 64'((2 ** F + 3) / 6);
  localparam logic signed [63:0] C120 = 64'((2 ** F + 60) / 120);

  typedef enum logic [2:0] {IDLE, WRAP, SIN, COS, RESP} state_t;

  state_t                  state, nstate;
  logic signed [XW-1:0]    x;
  logic [ID_BITS-1:0]      id_q;
  logic [ID_BITS-1:0]      last_q;
  logic [FLOAT_BITS-1:0]   sin_q, cos_q;

  logic                    gnt_found;
  logic [ID_BITS-1:0]      gnt_idx;
  logic [ID_BITS-1:0]      cand;
  logic                    accept;
  logic [FLOAT_BITS-1:0]   angle_in;
  logic signed [XW-1:0]    c;
  logic signed [XW-1:0]    op;
  logic [FLOAT_BITS-1:0]   poly_out;
  logic signed [63:0]      p, p2, p3, p5, t3, t5;

  // Map v in [-pi, 3pi/2] onto [-pi/2, pi/2] using sin symmetry.
  function automatic logic signed [XW-1:0] fold(input logic signed [XW-1:0] v);
    if (v > HALF_PI)      return PI - v;
    else if (v < NEG_HPI) return NEG_PI - v;
    else                  return v;
  endfunction

  // Round-robin grant: first valid requester after the last one served.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_BITS'((int'(last_q) + k) % N_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready only toward the granted requester, and only while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign accept   = (state == IDLE) && gnt_found;
  assign angle_in = bus.req_angle[int'(gnt_idx) * FLOAT_BITS +: FLOAT_BITS];
  assign c        = HALF_PI - x;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (accept) nstate = WRAP;
      WRAP: if (!(x >= PI) && !(x < NEG_PI)) nstate = SIN;
      SIN:  nstate = COS;
      COS:  nstate = RESP;
      RESP: if (bus.resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Operand mux for the shared polynomial; parked at zero when unused.
  always_comb begin
    op = '0;
    case (state)
      SIN:     op = fold(x);
      COS:     op = fold(c);
      default: op = '0;
    endcase
  end

  // sin(v) ~= v - v^3/6 + v^5/120, evaluated in 64-bit fixed point.
  always_comb begin
    p        = 64'(op);
    p2       = (p * p) >>> F;
    p3       = (p2 * p) >>> F;
    p5       = (p3 * p2) >>> F;
    t3       = (p3 * C6) >>> F;
    t5       = (p5 * C120) >>> F;
    poly_out = FLOAT_BITS'(p - t3 + t5);
  end

  // Angle load/reduction, grant bookkeeping and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      id_q   <= '0;
      last_q <= ID_BITS'(N_REQ - 1);
      sin_q  <= '0;
      cos_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x      <= {{2{angle_in[FLOAT_BITS-1]}}, angle_in};
          id_q   <= gnt_idx;
          last_q <= gnt_idx;
        end
        WRAP: begin
          if (x >= PI)          x <= x - TWO_PI;
          else if (x < NEG_PI)  x <= x + TWO_PI;
        end
        SIN: sin_q <= poly_out;
        COS: cos_q <= poly_out;
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = (state == RESP);
  assign bus.resp_id    = id_q;
  assign bus.resp_sin   = sin_q;
  assign bus.resp_cos   = cos_q;
  assign busy           = (state != IDLE);

endmodule

// File: doc/trig_scheduler.md
# trig_scheduler

Shared sine/cosine scheduler for the fixed-point math path. Up to `N_REQ` clients (piece rotators, renderers) request sin and cos of an arbitrary signed angle. The block arbitrates round-robin and reduces the angle iteratively to [-π, π). It then time-multiplexes one combinational `sin` polynomial instance twice, once for sin and once for cos = sin(π/2 − x), and returns both results on a valid/ready response port.

## Interface
- `N_REQ`, default 4: number of requesters, ≥ 1.
- `ID_BITS`, default `$clog2(N_REQ)` (min 1): requester id width.
- `clk`  input  1: clock.
- `rst`  input  1: reset, asynchronous, active-high.
- `req_valid`  input  N_REQ: per-requester request valid.
- `req_angle`  input  N_REQ×`FLOAT_BITS`: packed signed angles in radians, same fixed-point format as the math library (`FLOAT_DCM_BITS` fraction bits). Requester i occupies bits [i·FLOAT_BITS +: FLOAT_BITS].
- `req_ready`  output  N_REQ: one-hot or zero; requester i is accepted on an edge where `req_valid[i] && req_ready[i]`.
- `resp_valid`  output  1: result available.
- `resp_ready`  input  1: consumer accepts result.
- `resp_id`  output  ID_BITS: index of the requester that is served.
- `resp_sin`  output  `FLOAT_BITS`: sin(angle).
- `resp_cos`  output  `FLOAT_BITS`: cos(angle).
- `busy`  output  1: high in every state except IDLE.

## Operation
- Constants are block-local, rounded to `FLOAT_DCM_BITS`: PI, HALF_PI, TWO_PI.
- The angle register `x` is signed `FLOAT_BITS`+2 wide, sign-extended on load. All add/sub is done at this width. Outputs truncate to the low `FLOAT_BITS`.
- States: IDLE → WRAP → SIN → COS → RESP → IDLE.
- **IDLE:** the granted requester is the first i with `req_valid[i]`, searching from `last+1` (mod N_REQ) upward. `req_ready[i]` is driven combinationally for the granted i only; all `req_ready` are 0 outside IDLE.
  - On handshake: load `x` ← angle, `id` ← i, `last` ← i; go to WRAP.
- **WRAP:** one adjustment per cycle.
  - If x ≥ PI: x ← x − TWO_PI; stay.
  - Else if x < −PI: x ← x + TWO_PI; stay.
  - Else go to SIN.
- **SIN:** operand = fold(x). The `sin` output is registered into `resp_sin`. Go to COS.
- **COS:** c = HALF_PI − x. Operand = fold(c). The `sin` output is registered into `resp_cos`. Go to RESP.
- **fold(v):**
  - If v > HALF_PI: PI − v.
  - Else if v < −HALF_PI: −PI − v.
  - Else v.
  - The polynomial therefore only ever sees values in [−π/2, π/2].
- **RESP:** `resp_valid` = 1. `resp_id`, `resp_sin` and `resp_cos` are held stable until `resp_valid && resp_ready`; on that edge go to IDLE.
- The shared `sin` operand mux is driven only in SIN and COS. Its operand is 0 otherwise, to avoid toggling.

## Timing
- Reset values:
  - state IDLE.
  - `resp_valid`=0, `resp_id`=0, `resp_sin`=0, `resp_cos`=0, `busy`=0.
  - `last`=N_REQ−1, so requester 0 has first priority.
- Latency: with the handshake at edge T and k wrap adjustments, `resp_valid` rises at edge T+3+k.
  - k=0 for |angle| < π; k ≤ 2 for angles in [−4π, 4π).
  - Larger angles are still correct, with latency growing by 1 cycle per 2π.
- Throughput: no accept in the same cycle as the response handshake. The next accept is possible at edge R+1 (R = response handshake edge), giving k+5 cycles per op minimum.
- `resp_ready` held low stalls indefinitely in RESP. Requests wait; the grant is recomputed every IDLE cycle.
- `req_valid` dropping before the handshake is legal; the grant moves on.
- Simultaneous requests: exactly one grant per IDLE cycle, rotating past the last served index.
- Reset mid-operation aborts immediately. The in-flight request is lost; its requester must re-request.
- Boundaries:
  - x = PI exactly wraps to −PI.
  - x = −PI stays.
  - fold(±HALF_PI) passes unchanged.

## Test plan
- After reset, assert requester 0 with angle 0 → `req_ready[0]` 1 in the same cycle; `resp_valid` 3 cycles later. `resp_sin` = 0 exactly; `resp_cos` ≈ 1.0045 (polynomial at π/2), tolerance 0.01; `resp_id`=0.
- Angle 3π/4 → sin ≈ 0.7071, cos ≈ −0.7071, tolerance 0.01; latency 3 (fold path exercised).
- Angle 7.0 rad (k=1) → latency 4; sin ≈ 0.6570, cos ≈ 0.7539. Angle −11.0 rad (k=2) → latency 5; sin ≈ 1.0000, cos ≈ 0.0044.
- All four requesters valid continuously with angles 0.1·(i+1) → served in order 0,1,2,3,0,…; each `resp_id` matches its angle; no starvation over 16 ops.
- `resp_ready` low for 10 cycles in RESP → outputs stable, `req_ready` all 0, `busy`=1. On release: exactly one handshake, then IDLE.
- Assert `rst` during WRAP of a k=2 request → outputs zero asynchronously, `busy`=0. After release, the next request from requester 1 is served with `resp_id`=1.
